// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Packs a big-endian byte stream into 32-bit instruction-memory
//               writes and holds the CPU in reset until the load completes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h00003000,
  parameter int          IDX_W     = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  input  logic             byte_last,
  output logic             byte_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             cpu_reset_hold,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W:0]   word_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [IDX_W:0] c_capacity = {1'b1, {IDX_W{1'b0}}};

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_byte_idx;
  logic [31:0] r_pack;

  logic        w_accept;
  logic        w_complete;
  logic        w_full;
  logic        w_restart;
  logic [31:0] w_word;
  logic [31:0] w_addr;

  assign byte_ready = (r_state == ST_LOAD);
  assign w_accept   = byte_valid && byte_ready;
  assign w_complete = w_accept && ((r_byte_idx == 2'd3) || byte_last);
  assign w_full     = (word_count == c_capacity);
  assign w_restart  = start && (r_state != ST_LOAD);

  // Shift of 8*(3-idx) places the byte big-endian; ~idx equals 3-idx on 2 bits.
  assign w_word = r_pack | ({24'h0, byte_data} << {~r_byte_idx, 3'b000});
  assign w_addr = BASE_ADDR + {{(30 - IDX_W){1'b0}}, word_count[IDX_W-1:0], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_LOAD;
      ST_LOAD: begin
        if (w_complete) begin
          if (w_full)         w_next = ST_ERR;
          else if (byte_last) w_next = ST_DONE;
        end
      end
      ST_DONE: if (start) w_next = ST_LOAD;
      ST_ERR:  if (start) w_next = ST_LOAD;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_idx     <= 2'd0;
      r_pack         <= 32'h0;
      word_count     <= '0;
      imem_we        <= 1'b0;
      imem_addr      <= BASE_ADDR;
      imem_wdata     <= 32'h0;
      cpu_reset_hold <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      imem_we        <= 1'b0;
      busy           <= (w_next == ST_LOAD);
      done           <= (w_next == ST_DONE);
      error          <= (w_next == ST_ERR);
      cpu_reset_hold <= (w_next != ST_DONE);
      if (w_restart) begin
        word_count <= '0;
        r_byte_idx <= 2'd0;
        r_pack     <= 32'h0;
      end else if (w_accept) begin
        if (w_complete) begin
          r_byte_idx <= 2'd0;
          r_pack     <= 32'h0;
          // A full memory drops the word; the FSM moves to ERR on this edge.
          if (!w_full) begin
            imem_we    <= 1'b1;
            imem_addr  <= w_addr;
            imem_wdata <= w_word;
            word_count <= word_count + 1'b1;
          end
        end else begin
          r_byte_idx <= r_byte_idx + 2'd1;
          r_pack     <= w_word;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader (scoreboarded writes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam logic [31:0] c_base = 32'h00003000;
  localparam int          c_idxw = 2;
  localparam int          c_cap  = 4;

  logic              clk;
  logic              reset;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_last;
  logic              byte_ready;
  logic              imem_we;
  logic [31:0]       imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [c_idxw:0]   word_count;

  imem_loader #(.BASE_ADDR(c_base), .IDX_W(c_idxw)) dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset_hold(cpu_reset_hold),
    .busy(busy), .done(done), .error(error), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [63:0] sb[$];
  int          m_idx;
  int          m_wc;
  logic [31:0] m_word;

  typedef struct {
    int          n;
    logic [63:0] b;
    bit          gaps;
    int          exp_wc;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got %h@%h expected none", imem_wdata, imem_addr);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        check("write_addr", imem_addr, e[63:32]);
        check("write_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit last);
    @(negedge clk);
    check("byte_ready", 32'(byte_ready), 32'd1);
    byte_valid = 1'b1;
    byte_data  = b;
    byte_last  = last;
    m_word = m_word | ({b, 24'h0} >> (8 * m_idx));
    if (m_idx == 3 || last) begin
      if (m_wc < c_cap) begin
        sb.push_back({c_base + 32'(m_wc * 4), m_word});
        m_wc++;
      end
      m_idx  = 0;
      m_word = 32'h0;
    end else begin
      m_idx++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_last  = 1'b0;
    end
  endtask

  task automatic model_clear();
    m_idx  = 0;
    m_wc   = 0;
    m_word = 32'h0;
  endtask

  task automatic do_start();
    @(negedge clk);
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
    check("start_busy", 32'(busy), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_error", 32'(error), 32'd0);
    check("start_hold", 32'(cpu_reset_hold), 32'd1);
    check("start_wc", 32'(word_count), 32'd0);
  endtask

  task automatic check_done(input int exp_wc);
    idle(1);
    check("done", 32'(done), 32'd1);
    check("done_hold", 32'(cpu_reset_hold), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    check("done_ready", 32'(byte_ready), 32'd0);
    check("done_wc", 32'(word_count), 32'(exp_wc));
    idle(1);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{n: 4, b: 64'h34080001_00000000, gaps: 1'b0, exp_wc: 1};
    vecs[1] = '{n: 6, b: 64'h11223344_AABB0000, gaps: 1'b0, exp_wc: 2};
    vecs[2] = '{n: 8, b: 64'hCAFEBABE_12345678, gaps: 1'b1, exp_wc: 2};
    vecs[3] = '{n: 1, b: 64'h9C000000_00000000, gaps: 1'b0, exp_wc: 1};
    vecs[4] = '{n: 7, b: 64'h01020304_050607FF, gaps: 1'b1, exp_wc: 2};

    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h0; byte_last = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", imem_addr, c_base);
    check("rst_wdata", imem_wdata, 32'h0);
    check("rst_hold", 32'(cpu_reset_hold), 32'd1);
    check("rst_flags", {29'b0, busy, done, error}, 32'd0);
    check("rst_wc", 32'(word_count), 32'd0);
    check("rst_ready", 32'(byte_ready), 32'd0);

    for (int v = 0; v < 5; v++) begin
      logic [63:0] bb;
      bb = vecs[v].b;
      do_start();
      for (int i = 0; i < vecs[v].n; i++) begin
        send(bb[63 - 8*i -: 8], i == vecs[v].n - 1);
        if (vecs[v].gaps && i < vecs[v].n - 1) idle(2);
      end
      check_done(vecs[v].exp_wc);
    end

    // Bytes offered in DONE are ignored.
    @(negedge clk);
    byte_valid = 1'b1; byte_data = 8'h55; byte_last = 1'b1;
    idle(3);
    check("done_ignore_wc", 32'(word_count), 32'd2);
    check("done_ignore_done", 32'(done), 32'd1);

    // Overflow: four writes then ERR on the fifth completion.
    do_start();
    for (int i = 0; i < 20; i++) send(8'(i + 1), 1'b0);
    idle(1);
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_ready", 32'(byte_ready), 32'd0);
    check("ovf_wc", 32'(word_count), 32'd4);
    check("ovf_hold", 32'(cpu_reset_hold), 32'd1);
    idle(2);
    check("ovf_drained", 32'(sb.size()), 32'd0);

    // Reset mid-word discards the partial bytes.
    do_start();
    send(8'hDE, 1'b0);
    send(8'hAD, 1'b0);
    @(negedge clk);
    byte_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_hold", 32'(cpu_reset_hold), 32'd1);
    check("rmid_we", 32'(imem_we), 32'd0);
    check("rmid_ready", 32'(byte_ready), 32'd0);
    check("rmid_wc", 32'(word_count), 32'd0);
    do_start();
    send(8'hDE, 1'b0); send(8'hAD, 1'b0); send(8'hBE, 1'b0); send(8'hEF, 1'b1);
    check_done(1);

    // Reset during the write cycle: that write is seen, nothing after.
    do_start();
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
    @(negedge clk);
    byte_valid = 1'b0; byte_last = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rwr_we", 32'(imem_we), 32'd0);
    check("rwr_done", 32'(done), 32'd0);
    check("rwr_hold", 32'(cpu_reset_hold), 32'd1);
    check("rwr_addr_held", imem_addr, c_base);
    idle(3);
    check("rwr_drained", 32'(sb.size()), 32'd0);

    // Start during LOAD is ignored; start in DONE restarts at BASE.
    do_start();
    send(8'hA1, 1'b0); send(8'hA2, 1'b0);
    idle(1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("rload_busy", 32'(busy), 32'd1);
    send(8'hA3, 1'b0); send(8'hA4, 1'b0); send(8'hB1, 1'b1);
    check_done(2);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    model_clear();
    check("rdone_done", 32'(done), 32'd0);
    check("rdone_hold", 32'(cpu_reset_hold), 32'd1);
    check("rdone_wc", 32'(word_count), 32'd0);
    send(8'hC3, 1'b1);
    check_done(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
